output_mode_sequencer: RTL
==========================

Name: output_mode_sequencer

Overview:
Parametrised successor to the fixed single-output mode FSM. It selects one of NUM_MODES waveform/output generators from an encoded mode_select bus and drives a one-hot enable vector. Before acting on a new selection, the selection must be held stable for a set number of cycles. Whenever the block switches between two active modes, it inserts break-before-make dead time with all enables low. It sits between the board switch/control inputs and the generator blocks (triangle, R2R, buzzer, sawtooth, and future generators).

Parameters:
NUM_MODES, 4, number of generator outputs; must be >= 2
SEL_W, $clog2(NUM_MODES+1), width of the mode code; code 0 = OFF, codes 1..NUM_MODES = mode_enable[code-1]
STABLE_CYCLES, 16, consecutive cycles mode_select must hold a value before it is accepted; must be >= 1
DEAD_CYCLES, 4, all-off cycles inserted between two different non-OFF modes; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
mode_select  input  SEL_W  requested mode code (asynchronous to logic intent, e.g. switches)
mode_enable  output  NUM_MODES  one-hot enable, or all-zero when off or in dead time; registered
active_mode  output  SEL_W  code of the mode currently driven (0 when off or in dead time); registered
switching  output  1  high during dead time; registered
mode_changed  output  1  one-cycle pulse on the cycle mode_enable first shows a new non-zero value; registered
sel_invalid  output  1  high while the registered selection is an out-of-range code (> NUM_MODES); registered

Behaviour:
- Reset:
  - Interface: one clock; reset is synchronous and active-low.
  - At a rising clk edge with reset = 0, all outputs and internal registers clear to 0 and the state goes to S_OFF.
  - Reset asserted mid-dead-time or mid-qualification aborts it; enables are low from that edge onward.
- Input stage:
  - mode_select is registered once into sel_q.
  - Out-of-range codes are treated as OFF (0) and raise sel_invalid.
- Qualifier:
  - cand register plus stability counter cnt.
  - If sel_q != cand: cand <= sel_q, cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
  - qual_valid = (cnt == STABLE_CYCLES-1); qual_sel = cand.
- Glitch rejection: a mode_select change that does not persist STABLE_CYCLES cycles has no effect on any output.
- States: S_OFF, S_ACTIVE, S_DEAD.
  - S_OFF: if qual_valid and qual_sel != 0, go to S_ACTIVE, load active_mode = qual_sel, set the enable, pulse mode_changed.
  - S_ACTIVE, qual_valid and qual_sel == 0: go to S_OFF. Enables drop the next edge; no dead time is required for turn-off.
  - S_ACTIVE, qual_valid and qual_sel != 0 and != active_mode: go to S_DEAD, clear enables and active_mode, latch target = qual_sel, load dead counter to 0, set switching.
  - S_ACTIVE, qual_valid and qual_sel == active_mode: no action.
  - S_DEAD: dead counter increments each cycle.
    - When it reaches DEAD_CYCLES-1, go to S_ACTIVE with active_mode = target, set the enable, pulse mode_changed, clear switching.
    - Enables are therefore low for exactly DEAD_CYCLES cycles.
  - S_DEAD, new qualified value != target: if it is 0, go to S_OFF immediately. Otherwise retarget without restarting the dead counter.
  - S_DEAD, new qualified value equal to the pre-switch mode: dead time still completes.
- Latency from S_OFF: mode_enable goes high after the (STABLE_CYCLES+2)-th rising edge at which mode_select holds the new value. Edges are counted from the first edge that samples it.
- Latency for a mode-to-mode switch: enables drop at that same edge, and the new enable rises DEAD_CYCLES edges later.
- Invariant: at most one bit of mode_enable is ever high, and never two different modes on consecutive cycles.

Decomposition:
- Package output_mode_pkg contains:
  - state enum (S_OFF, S_ACTIVE, S_DEAD)
  - constant MODE_OFF = 0
  - function code_to_onehot(code, NUM_MODES), returning zero for 0 or out-of-range codes
- One sub-module, mode_select_qualifier, containing the input register, the range check and the stability counter.
  - Ports: clk, reset, mode_select, qual_sel, qual_valid, sel_invalid.
- The top level holds the FSM, the dead counter and the output registers.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with mode_select = 2 -> mode_enable = 0, active_mode = 0, switching = 0 throughout. Release reset -> mode_enable = 4'b0010 after the 18th edge (STABLE_CYCLES = 16), with mode_changed high for one cycle.
- Glitch rejection: from OFF, pulse mode_select = 3 for 10 cycles, then return to 0 -> no output change, mode_changed never pulses.
- Switch with dead time: active mode 1 (4'b0001), then mode_select = 4 held -> enables drop to 0 after the 18th edge, switching is high for 4 cycles, then 4'b1000, active_mode = 4, one mode_changed pulse.
- Turn-off: active mode 3, then mode_select = 0 held 16 cycles -> mode_enable = 0 with no switching pulse.
- Retarget or abort during dead time: switch from mode 1 toward 2, then qualify 0 during dead time -> S_OFF immediately, no mode_changed. Repeat, qualifying 3 instead -> mode 3 enabled at the original dead-time end.
- Invalid and reset-mid-op: mode_select = 7 with NUM_MODES = 4 -> sel_invalid = 1, behaves as OFF. Assert reset during S_DEAD -> all outputs 0 at that edge. A one-hot assertion holds for the whole run.

Source files
------------

// File: rtl/output_mode_pkg.sv
// Shared types and helpers for the output mode sequencer.
package output_mode_pkg;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_ACTIVE = 2'd1,
        S_DEAD   = 2'd2
    } state_t;

    // Code 0 always means "no generator driven".
    localparam int MODE_OFF  = 0;

    // Widest enable vector / code the helper supports; NUM_MODES must not exceed MAX_MODES.
    localparam int MAX_MODES = 32;
    localparam int CODE_W    = 8;

    // Mode code -> one-hot enable; OFF and out-of-range codes give all zeros.
    function automatic logic [MAX_MODES-1:0] code_to_onehot(
        input logic [CODE_W-1:0] code,
        input int unsigned       num_modes
    );
        logic [MAX_MODES-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_MODES; i++) begin
            if ((i < num_modes) && (code == CODE_W'(i + 1))) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/mode_select_qualifier.sv
// Registers the raw mode code, maps out-of-range codes to OFF and only
// reports a selection once it has been stable for STABLE_CYCLES cycles.
module mode_select_qualifier
    import output_mode_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SEL_W         = $clog2(NUM_MODES + 1),
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] mode_select,
    output logic [SEL_W-1:0] qual_sel,
    output logic             qual_valid,
    output logic             sel_invalid
);

    localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_invalid_q, sel_invalid_d;
    logic             out_of_range;

    // Range check on the raw input, then restart or advance the stability count.
    always_comb begin
        out_of_range  = (mode_select > SEL_W'(NUM_MODES));
        sel_invalid_d = out_of_range;
        sel_d         = out_of_range ? SEL_W'(MODE_OFF) : mode_select;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        if (sel_q != cand_q) begin
            cand_d = sel_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // Input register, candidate and counter; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q         <= '0;
            sel_invalid_q <= 1'b0;
            cand_q        <= '0;
            cnt_q         <= '0;
        end else begin
            sel_q         <= sel_d;
            sel_invalid_q <= sel_invalid_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
        end
    end

    assign qual_sel    = cand_q;
    assign qual_valid  = (cnt_q == CNT_MAX);
    assign sel_invalid = sel_invalid_q;

endmodule

// File: rtl/output_mode_sequencer.sv
// Selects one of NUM_MODES generators from a qualified mode code and drives a
// one-hot enable, inserting all-off dead time between two different modes.
module output_mode_sequencer
    import output_mode_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SEL_W         = $clog2(NUM_MODES + 1),
    parameter int STABLE_CYCLES = 16,
    parameter int DEAD_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SEL_W-1:0]     mode_select,
    output logic [NUM_MODES-1:0] mode_enable,
    output logic [SEL_W-1:0]     active_mode,
    output logic                 switching,
    output logic                 mode_changed,
    output logic                 sel_invalid
);

    localparam int                DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [SEL_W-1:0]  OFF_CODE  = SEL_W'(MODE_OFF);

    logic [SEL_W-1:0]     qual_sel;
    logic                 qual_valid;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     active_q, active_d;
    logic [SEL_W-1:0]     target_q, target_d;
    logic [SEL_W-1:0]     next_target;
    logic [DEAD_W-1:0]    dead_q, dead_d;
    logic [NUM_MODES-1:0] en_q, en_d;
    logic                 sw_q, sw_d;
    logic                 chg_q, chg_d;
    logic [MAX_MODES-1:0] oh_full;
    logic                 unused_oh;

    mode_select_qualifier #(
        .NUM_MODES     (NUM_MODES),
        .SEL_W         (SEL_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_qual (
        .clk         (clk),
        .reset       (reset),
        .mode_select (mode_select),
        .qual_sel    (qual_sel),
        .qual_valid  (qual_valid),
        .sel_invalid (sel_invalid)
    );

    // Next-state logic; the enable vector is always the one-hot of the next active code.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        target_d    = target_q;
        dead_d      = dead_q;
        sw_d        = sw_q;
        chg_d       = 1'b0;
        next_target = target_q;

        case (state_q)
            S_OFF: begin
                if (qual_valid && (qual_sel != OFF_CODE)) begin
                    state_d  = S_ACTIVE;
                    active_d = qual_sel;
                    chg_d    = 1'b1;
                end
            end

            S_ACTIVE: begin
                if (qual_valid) begin
                    if (qual_sel == OFF_CODE) begin
                        // Turn-off needs no dead time.
                        state_d  = S_OFF;
                        active_d = OFF_CODE;
                    end else if (qual_sel != active_q) begin
                        state_d  = S_DEAD;
                        active_d = OFF_CODE;
                        target_d = qual_sel;
                        dead_d   = '0;
                        sw_d     = 1'b1;
                    end
                end
            end

            S_DEAD: begin
                // A newly qualified mode retargets without restarting the dead count.
                if (qual_valid && (qual_sel != target_q)) begin
                    next_target = qual_sel;
                end
                if (qual_valid && (qual_sel == OFF_CODE)) begin
                    state_d  = S_OFF;
                    target_d = OFF_CODE;
                    dead_d   = '0;
                    sw_d     = 1'b0;
                end else if (dead_q == DEAD_LAST) begin
                    state_d  = S_ACTIVE;
                    active_d = next_target;
                    target_d = OFF_CODE;
                    dead_d   = '0;
                    sw_d     = 1'b0;
                    chg_d    = 1'b1;
                end else begin
                    target_d = next_target;
                    dead_d   = dead_q + DEAD_W'(1);
                end
            end

            default: begin
                state_d  = S_OFF;
                active_d = OFF_CODE;
                target_d = OFF_CODE;
                dead_d   = '0;
                sw_d     = 1'b0;
            end
        endcase

        oh_full   = code_to_onehot(CODE_W'(active_d), NUM_MODES);
        en_d      = oh_full[NUM_MODES-1:0];
        unused_oh = ^oh_full;
    end

    // FSM state and registered outputs; reset aborts qualification or dead time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_OFF;
            active_q <= '0;
            target_q <= '0;
            dead_q   <= '0;
            en_q     <= '0;
            sw_q     <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            target_q <= target_d;
            dead_q   <= dead_d;
            en_q     <= en_d;
            sw_q     <= sw_d;
            chg_q    <= chg_d;
        end
    end

    assign mode_enable  = en_q;
    assign active_mode  = active_q;
    assign switching    = sw_q;
    assign mode_changed = chg_q;

endmodule
